// File: rtl/mux_scan_seq.sv
// mux_scan_seq
//   Drives the 4-bit select of a 16:1 mux tree and samples its output,
//   sweeping channels 0..15 in order. Masked channels are skipped (one
//   cycle, bit forced to 0). Enabled channels are held for SETTLE cycles
//   before sampling. The assembled 16-bit word is offered with a
//   valid/ready handshake, and done pulses once the word has been accepted.
//
//   Optional feature macro: SCAN_PARITY_EN (adds a 'parity' output, the XOR
//   of the word bits, updated together with word).
//
// Parameters
//   SETTLE  cycles sel is held on an enabled channel before sampling (0..15)
//   CNT_W   settle counter width, must hold SETTLE
//
// Ports
//   clk         rising-edge clock
//   rst_n       asynchronous active-low reset
//   start       begin one sweep (sampled in IDLE only)
//   chan_mask   channel enables, latched at start
//   sel         mux select
//   mux_out     mux output bit
//   busy        sweep/handshake in progress
//   word        captured word (bit i = channel i, 0 if masked)
//   word_valid  word is complete and stable
//   word_ready  consumer accepts word
//   done        one-cycle pulse after the handshake
//   parity      XOR of word bits (SCAN_PARITY_EN only)
//
// state      | meaning
// -----------+-------------------------------------------------------
// ST_IDLE    | waiting for start, sel parked at 0
// ST_SETTLE  | sel=ptr, counting down settle cycles
// ST_SAMPLE  | sel=ptr, capture word[ptr] at the ending edge
// ST_HOLD    | word_valid high, waiting for word_ready

module mux_scan_seq #(
    parameter int SETTLE = 1,
    parameter int CNT_W  = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [15:0] chan_mask,
    output logic [3:0]  sel,
    input  logic        mux_out,
    output logic        busy,
    output logic [15:0] word,
    output logic        word_valid,
    input  logic        word_ready,
`ifdef SCAN_PARITY_EN
    output logic        parity,
`endif
    output logic        done
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SETTLE = 2'd1;
    localparam logic [1:0] ST_SAMPLE = 2'd2;
    localparam logic [1:0] ST_HOLD   = 2'd3;

    // Down-counter is loaded with SETTLE-1 so the SETTLE state lasts
    // exactly SETTLE cycles; with SETTLE=0 the state is never entered.
    localparam logic             HAS_SETTLE  = (SETTLE > 0);
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE > 0 ? SETTLE - 1 : 0);

    logic [1:0]       state, state_d;
    logic [3:0]       ptr, ptr_d;
    logic [CNT_W-1:0] cnt, cnt_d;
    logic [15:0]      mask_q, mask_d;
    logic [15:0]      word_d;
    logic             done_d;

    always_comb begin
        state_d = state;
        ptr_d   = ptr;
        cnt_d   = cnt;
        mask_d  = mask_q;
        word_d  = word;
        done_d  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    mask_d = chan_mask;
                    ptr_d  = 4'd0;
                    word_d = 16'h0000;
                    if (chan_mask[0] && HAS_SETTLE) begin
                        state_d = ST_SETTLE;
                        cnt_d   = SETTLE_LAST;
                    end else begin
                        state_d = ST_SAMPLE;
                    end
                end
            end
            ST_SETTLE: begin
                if (cnt == '0) begin
                    state_d = ST_SAMPLE;
                end else begin
                    cnt_d = cnt - CNT_W'(1);
                end
            end
            ST_SAMPLE: begin
                word_d[ptr] = mask_q[ptr] & mux_out;
                if (ptr == 4'd15) begin
                    state_d = ST_HOLD;
                end else begin
                    ptr_d = ptr + 4'd1;
                    if (mask_q[ptr_d] && HAS_SETTLE) begin
                        state_d = ST_SETTLE;
                        cnt_d   = SETTLE_LAST;
                    end else begin
                        state_d = ST_SAMPLE;
                    end
                end
            end
            ST_HOLD: begin
                if (word_ready) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= ST_IDLE;
            ptr    <= 4'd0;
            cnt    <= '0;
            mask_q <= 16'h0000;
            word   <= 16'h0000;
            done   <= 1'b0;
        end else begin
            state  <= state_d;
            ptr    <= ptr_d;
            cnt    <= cnt_d;
            mask_q <= mask_d;
            word   <= word_d;
            done   <= done_d;
        end
    end

`ifdef SCAN_PARITY_EN
    // Tracks word_d so it is always consistent with word, including the clear at start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            parity <= 1'b0;
        end else begin
            parity <= ^word_d;
        end
    end
`endif

    // sel is parked at 0 outside the active sweep states.
    assign sel        = (state == ST_SETTLE || state == ST_SAMPLE) ? ptr : 4'd0;
    assign busy       = (state != ST_IDLE);
    assign word_valid = (state == ST_HOLD);

endmodule

// File: tb/tb_mux_scan_seq.sv
module tb_mux_scan_seq;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [15:0] chan_mask;
    logic [3:0]  sel;
    logic        mux_out;
    logic        busy;
    logic [15:0] word;
    logic        word_valid;
    logic        word_ready;
    logic        done;
`ifdef SCAN_PARITY_EN
    logic        parity;
`endif

    logic [15:0] mux_in;
    logic        rand_mode;
    logic        rand_bit;

    int n_cmp;
    int n_fail;
    int sel_log[$];

    mux_scan_seq #(.SETTLE(1), .CNT_W(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .chan_mask  (chan_mask),
        .sel        (sel),
        .mux_out    (mux_out),
        .busy       (busy),
        .word       (word),
        .word_valid (word_valid),
        .word_ready (word_ready),
`ifdef SCAN_PARITY_EN
        .parity     (parity),
`endif
        .done       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Mux model: normally the selected input; random noise when rand_mode is set.
    assign mux_out = rand_mode ? rand_bit : mux_in[sel];
    always @(negedge clk) rand_bit <= 1'($urandom);

    task automatic issue_start(input logic [15:0] m, input logic [15:0] m_after);
        @(negedge clk);
        chan_mask = m;
        start     = 1'b1;
        @(negedge clk);
        start     = 1'b0;
        chan_mask = m_after;
    endtask

    // Called at the negedge right after the start edge (edge 1).
    task automatic wait_valid(output int edges);
        edges = 1;
        sel_log.delete();
        while (!word_valid && edges < 200) begin
            sel_log.push_back(int'(sel));
            @(negedge clk);
            edges++;
        end
    endtask

    task automatic test_reset();
        #1;
        n_cmp++;
        if (sel !== 4'd0 || word !== 16'h0 || word_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_outputs: sel=%h word=%h valid=%b busy=%b done=%b, required all 0",
                     sel, word, word_valid, busy, done);
        end
`ifdef SCAN_PARITY_EN
        n_cmp++;
        if (parity !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_parity: got %b required 0", parity);
        end
`endif
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_full_sweep();
        int e;
        int exp_sel[$];
        logic ok;
        mux_in     = 16'hA5C3;
        word_ready = 1'b1;
        issue_start(16'hFFFF, 16'h0000);
        wait_valid(e);
        n_cmp++;
        if (e !== 33) begin
            n_fail++;
            $display("FAIL full_latency: got %0d edges required 33", e);
        end
        n_cmp++;
        if (word !== 16'hA5C3) begin
            n_fail++;
            $display("FAIL full_word: got %h required a5c3", word);
        end
        exp_sel.delete();
        for (int c = 0; c < 16; c++) begin
            exp_sel.push_back(c);
            exp_sel.push_back(c);
        end
        ok = (sel_log.size() == exp_sel.size());
        if (ok) foreach (exp_sel[i]) if (sel_log[i] != exp_sel[i]) ok = 1'b0;
        n_cmp++;
        if (!ok) begin
            n_fail++;
            $display("FAIL full_sel_seq: got %0d entries, required 32 entries 0,0,1,1,..,15,15", sel_log.size());
        end
        n_cmp++;
        if (busy !== 1'b1 || sel !== 4'd0) begin
            n_fail++;
            $display("FAIL full_hold: busy=%b sel=%h required busy=1 sel=0", busy, sel);
        end
        @(negedge clk);
        n_cmp++;
        if (done !== 1'b1 || word_valid !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL full_done: done=%b valid=%b busy=%b required 1,0,0", done, word_valid, busy);
        end
        @(negedge clk);
        n_cmp++;
        if (done !== 1'b0 || word !== 16'hA5C3) begin
            n_fail++;
            $display("FAIL full_done_pulse: done=%b word=%h required done=0 word=a5c3", done, word);
        end
    endtask

    task automatic test_sparse_mask();
        int e;
        int exp_sel[$];
        logic ok;
        mux_in     = 16'hFFFF;
        word_ready = 1'b1;
        issue_start(16'h00F0, 16'hFFFF);
        wait_valid(e);
        n_cmp++;
        if (e !== 21) begin
            n_fail++;
            $display("FAIL sparse_latency: got %0d edges required 21", e);
        end
        n_cmp++;
        if (word !== 16'h00F0) begin
            n_fail++;
            $display("FAIL sparse_word: got %h required 00f0", word);
        end
        exp_sel.delete();
        for (int c = 0; c < 16; c++) begin
            if (c >= 4 && c <= 7) exp_sel.push_back(c);
            exp_sel.push_back(c);
        end
        ok = (sel_log.size() == exp_sel.size());
        if (ok) foreach (exp_sel[i]) if (sel_log[i] != exp_sel[i]) ok = 1'b0;
        n_cmp++;
        if (!ok) begin
            n_fail++;
            $display("FAIL sparse_sel_seq: got %0d entries, required 20 with dwell on 4..7", sel_log.size());
        end
        @(negedge clk);
        n_cmp++;
        if (done !== 1'b1) begin
            n_fail++;
            $display("FAIL sparse_done: got %b required 1", done);
        end
        @(negedge clk);
    endtask

    task automatic test_empty_mask();
        int e;
        rand_mode  = 1'b1;
        word_ready = 1'b1;
        issue_start(16'h0000, 16'hFFFF);
        wait_valid(e);
        rand_mode = 1'b0;
        n_cmp++;
        if (e !== 17) begin
            n_fail++;
            $display("FAIL empty_latency: got %0d edges required 17", e);
        end
        n_cmp++;
        if (word !== 16'h0000) begin
            n_fail++;
            $display("FAIL empty_word: got %h required 0000", word);
        end
        @(negedge clk);
        n_cmp++;
        if (done !== 1'b1) begin
            n_fail++;
            $display("FAIL empty_done: got %b required 1", done);
        end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        int e;
        mux_in     = 16'hA5C3;
        word_ready = 1'b0;
        issue_start(16'hFFFF, 16'hFFFF);
        wait_valid(e);
        n_cmp++;
        if (e !== 33) begin
            n_fail++;
            $display("FAIL hold_latency: got %0d edges required 33", e);
        end
        for (int i = 0; i < 10; i++) begin
            start  = (i % 2 == 0) && (i < 9);
            mux_in = 16'h0F0F;
            @(negedge clk);
            n_cmp++;
            if (word_valid !== 1'b1 || word !== 16'hA5C3 || busy !== 1'b1) begin
                n_fail++;
                $display("FAIL hold_cycle%0d: valid=%b word=%h busy=%b required 1,a5c3,1",
                         i, word_valid, word, busy);
            end
        end
        start      = 1'b0;
        word_ready = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (done !== 1'b1 || word_valid !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL hold_done: done=%b valid=%b busy=%b required 1,0,0", done, word_valid, busy);
        end
        // Start in the done cycle must be accepted.
        mux_in    = 16'h1234;
        chan_mask = 16'hFFFF;
        start     = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n_cmp++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_accept: busy=%b required 1", busy);
        end
        wait_valid(e);
        n_cmp++;
        if (e !== 33 || word !== 16'h1234) begin
            n_fail++;
            $display("FAIL b2b_word: edges=%0d word=%h required 33,1234", e, word);
        end
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset_mid_sweep();
        int e;
        int guard;
        mux_in     = 16'hA5C3;
        word_ready = 1'b1;
        issue_start(16'hFFFF, 16'hFFFF);
        guard = 0;
        while (sel !== 4'd7 && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        n_cmp++;
        if (guard >= 100) begin
            n_fail++;
            $display("FAIL rst_reach_ch7: sel=%h required 7 within 100 cycles", sel);
        end
        #2 rst_n = 1'b0;
        #1;
        n_cmp++;
        if (sel !== 4'd0 || word !== 16'h0 || word_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_mid_outputs: sel=%h word=%h valid=%b busy=%b done=%b required all 0",
                     sel, word, word_valid, busy, done);
        end
        @(negedge clk);
        rst_n  = 1'b1;
        mux_in = 16'h5A3C;
        issue_start(16'hFFFF, 16'hFFFF);
        wait_valid(e);
        n_cmp++;
        if (e !== 33 || word !== 16'h5A3C) begin
            n_fail++;
            $display("FAIL rst_new_sweep: edges=%0d word=%h required 33,5a3c", e, word);
        end
        @(negedge clk);
        @(negedge clk);
    endtask

`ifdef SCAN_PARITY_EN
    task automatic test_parity();
        int e;
        word_ready = 1'b1;
        mux_in     = 16'h0001;
        issue_start(16'hFFFF, 16'hFFFF);
        wait_valid(e);
        n_cmp++;
        if (word !== 16'h0001 || parity !== 1'b1) begin
            n_fail++;
            $display("FAIL parity_odd: word=%h parity=%b required 0001,1", word, parity);
        end
        @(negedge clk);
        mux_in = 16'h0003;
        issue_start(16'hFFFF, 16'hFFFF);
        wait_valid(e);
        n_cmp++;
        if (word !== 16'h0003 || parity !== 1'b0) begin
            n_fail++;
            $display("FAIL parity_even: word=%h parity=%b required 0003,0", word, parity);
        end
        @(negedge clk);
    endtask
`endif

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_cmp      = 0;
        n_fail     = 0;
        rst_n      = 1'b0;
        start      = 1'b0;
        chan_mask  = 16'h0;
        word_ready = 1'b0;
        mux_in     = 16'h0;
        rand_mode  = 1'b0;
        test_reset();
        test_full_sweep();
        test_sparse_mask();
        test_empty_mask();
        test_back_to_back();
        test_reset_mid_sweep();
`ifdef SCAN_PARITY_EN
        test_parity();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/mux_scan_seq.md
Name: mux_scan_seq

Overview:
- Sequencer directly upstream and downstream of the 16:1 mux tree: drives its 4-bit select and samples its 1-bit output.
- Sweeps channels 0..15 in order, skipping masked channels, and assembles the 16 sampled bits into a parallel word.
- Presents the word with a valid/ready handshake.
- Net function: a controlled, settle-timed parallel-to-serial-to-parallel capture of the 16 mux inputs.

Parameters:
- SETTLE, 1: cycles sel is held on an enabled channel before sampling. Legal range 0..15; 0 means sample in the same cycle sel is driven.
- CNT_W, 4: width of the settle counter. Must hold SETTLE.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  begin one sweep; sampled only in IDLE
- chan_mask  input  16  channel enable; bit i=1 means channel i is sampled. Latched at start.
- sel  output  4  select driven to the mux
- mux_out  input  1  mux output bit
- busy  output  1  high from the cycle after start until the handshake completes
- word  output  16  captured word; bit i = sample of channel i, 0 if masked
- word_valid  output  1  word is stable and complete
- word_ready  input  1  consumer accepts word
- done  output  1  one-cycle pulse in the cycle after the handshake completes

Behaviour:
- Reset (async assert, sync deassert via clk): state=IDLE, sel=0, word=0, word_valid=0, busy=0, done=0, ptr=0, settle count=0, latched mask=0. Reset mid-sweep aborts immediately; no partial word is presented.
- States: IDLE, SETTLE, SAMPLE, HOLD.
- IDLE:
  - sel=0.
  - On start=1: latch chan_mask, ptr=0, clear word, busy=1.
  - Next state is SETTLE if mask[0]=1 and SETTLE>0, otherwise SAMPLE.
- SETTLE:
  - sel=ptr. Counts SETTLE cycles.
  - On the last count, go to SAMPLE.
- SAMPLE (exactly 1 cycle per channel):
  - sel=ptr.
  - Write word[ptr] = mask[ptr] ? mux_out : 0 at the ending edge.
  - If ptr=15: go to HOLD.
  - Otherwise ptr+1; next state is SETTLE if mask[ptr+1]=1 and SETTLE>0, else SAMPLE.
  - Masked channels therefore cost exactly 1 cycle.
- HOLD:
  - sel=0, word_valid=1, word frozen.
  - Handshake completes on the edge where word_valid=1 and word_ready=1.
  - At that edge: word_valid→0, busy→0, done→1 for one cycle, go to IDLE. word keeps its value until the next start.
- Latency from the start edge to word_valid high = 1 + 16 + (enabled channel count × SETTLE) edges.
  - All enabled, SETTLE=1: 33.
  - Mask=0: 17.
- Boundary cases:
  - start while not IDLE: ignored.
  - chan_mask changes mid-sweep: no effect.
  - mux_out is sampled only in SAMPLE.
  - word_ready high before word_valid: no effect.
  - start in the done cycle (state IDLE) is accepted.
  - ptr never wraps within a sweep; 15 always ends the sweep.

Optional Feature:
- Macro: SCAN_PARITY_EN.
- Defined:
  - Adds output parity (1 bit): XOR of the 16 word bits.
  - Updated alongside word, valid whenever word_valid=1, reset value 0.
- Undefined: no parity port or logic exists; all other behaviour is identical.

Test Plan:
- Mux inputs = 16'hA5C3, mask=16'hFFFF, SETTLE=1, word_ready held 1 → word=16'hA5C3; word_valid rises 33 edges after start; done pulses 1 cycle; sel sequence 0,0,1,1,...,15,15.
- Inputs = 16'hFFFF, mask=16'h00F0 → word=16'h00F0; sel dwells 2 cycles only on 4..7; word_valid after 1+16+4 = 21 edges.
- mask=16'h0000 → word=16'h0000 after 17 edges; mux_out is never sampled, checked by toggling it randomly.
- word_ready held 0 for 10 cycles after word_valid → word_valid stays 1, word stays 16'hA5C3, busy=1; start pulses are ignored; ready=1 → done the next cycle.
- rst_n pulled low at channel 7 of a sweep → all outputs 0 immediately; a new start produces a clean full word.
- SCAN_PARITY_EN defined, word=16'h0001 → parity=1; word=16'h0003 → parity=0.
